// File: rtl/simd_lane_packer.sv
// Collects tagged 32-bit lane results into a 128-bit vector and holds it for a valid/ready consumer.
// Optional macro DUP_LANE_ERR_EN builds a sticky duplicate-lane error flag on err_dup.
`timescale 1ns/1ps
module simd_lane_packer #(
  parameter int LANE_W  = 32,
  parameter int N_LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_indice,
  input  logic [LANE_W-1:0]         in_dato,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*LANE_W-1:0] out_vector,
  output logic [N_LANES-1:0]        out_mask,
  output logic                      err_dup
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                           r_state;
  logic [N_LANES-1:0][LANE_W-1:0]   r_acc;
  logic [N_LANES-1:0]               r_mask;
  logic                             r_in_ready;
  logic                             r_out_valid;

  logic                             w_accept;
  logic [N_LANES-1:0]               w_mask_nxt;
  logic                             w_close;

  assign w_accept   = (r_state == COLLECT) && r_in_ready && in_valid;
  assign w_mask_nxt = r_mask | (N_LANES'(1) << in_indice);
  assign w_close    = w_accept && (in_last || (&w_mask_nxt));

  // in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_acc       <= '0;
      r_mask      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == COLLECT) begin
      r_in_ready <= 1'b1;
      if (w_accept) begin
        r_acc[in_indice] <= in_dato;
        r_mask           <= w_mask_nxt;
        if (w_close) begin
          r_state     <= HOLD;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end else if (out_ready) begin
      r_acc       <= '0;
      r_mask      <= '0;
      r_state     <= COLLECT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_vector = r_acc;
  assign out_mask   = r_mask;

`ifdef DUP_LANE_ERR_EN
  logic r_err_dup;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_err_dup <= 1'b0;
    else if (w_accept && r_mask[in_indice]) r_err_dup <= 1'b1;
  end
  assign err_dup = r_err_dup;
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_simd_lane_packer.sv
// Directed plus randomized bench for simd_lane_packer against a lane-array reference model.
`timescale 1ns/1ps
module tb_simd_lane_packer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_indice = '0;
  logic [31:0]  in_dato = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_vector;
  logic [3:0]   out_mask;
  logic         err_dup;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] m_lane[4];
  logic [3:0]  m_mask;
  bit          m_err;

  simd_lane_packer #(.LANE_W(32), .N_LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_indice(in_indice), .in_dato(in_dato), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .out_mask(out_mask), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] m_vec();
    return {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
  endfunction

  function automatic logic m_err_out();
`ifdef DUP_LANE_ERR_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_mask = '0;
  endtask

  // Called just after a rising edge; asserts reset between edges to prove it is asynchronous.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_clear();
    m_err = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mask", out_mask, 4'h0);
    chk("rst_vector", out_vector, 128'h0);
    chk("rst_err_dup", err_dup, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready_after", in_ready, 1'b1);
    chk("rst_out_valid_after", out_valid, 1'b0);
  endtask

  task automatic wr(input int idx, input logic [31:0] data, input bit last, output bit close);
    chk("pre_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_indice = 2'(idx); in_dato = data; in_last = last;
    if (m_mask[idx]) m_err = 1'b1;
    m_lane[idx] = data;
    m_mask[idx] = 1'b1;
    close = last || (m_mask == 4'hF);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("wr_out_valid", out_valid, close);
    chk("wr_in_ready", in_ready, !close);
    chk("wr_vector", out_vector, m_vec());
    chk("wr_mask", out_mask, m_mask);
    chk("wr_err_dup", err_dup, m_err_out());
  endtask

  // Holds for 'stall' cycles with junk writes that must be ignored, then consumes.
  task automatic consume(input int stall);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_indice = 2'($urandom_range(0, 3)); in_dato = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_vector", out_vector, m_vec());
      chk("hold_mask", out_mask, m_mask);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_clear();
    chk("cons_out_valid", out_valid, 1'b0);
    chk("cons_in_ready", in_ready, 1'b1);
    chk("cons_vector", out_vector, m_vec());
    chk("cons_mask", out_mask, 4'h0);
  endtask

  initial begin
    bit c;
    m_clear();
    m_err = 1'b0;
    do_reset();

    // Full in-order vector
    wr(0, 32'h11111111, 0, c);
    wr(1, 32'h22222222, 0, c);
    wr(2, 32'h33333333, 0, c);
    wr(3, 32'h44444444, 0, c);
    chk("full_vector", out_vector, 128'h44444444_33333333_22222222_11111111);
    consume(0);

    // Out-of-order with 3 cycles of backpressure
    wr(2, 32'hAABBCCDD, 0, c);
    wr(0, 32'h12345678, 0, c);
    wr(3, 32'h0F0F0F0F, 0, c);
    wr(1, 32'h87654321, 0, c);
    chk("ooo_vector", out_vector, 128'h0F0F0F0F_AABBCCDD_87654321_12345678);
    consume(3);

    // Single-lane vector closed by in_last
    wr(1, 32'hDEADBEEF, 1, c);
    chk("partial_vector", out_vector, 128'h00000000_00000000_DEADBEEF_00000000);
    chk("partial_mask", out_mask, 4'b0010);
    consume(1);

    // Overwrite of lane 0
    wr(0, 32'h00000001, 0, c);
    wr(0, 32'h00000002, 0, c);
    wr(1, 32'h00000011, 0, c);
    wr(2, 32'h00000022, 0, c);
    wr(3, 32'h00000033, 0, c);
    chk("ovw_lane0", out_vector[31:0], 32'h00000002);
    consume(0);
    chk("ovw_err_sticky", err_dup, m_err_out());

    // Reset mid-vector, then a clean full vector
    wr(0, 32'hCAFE0000, 0, c);
    wr(2, 32'hCAFE0002, 0, c);
    do_reset();
    wr(3, 32'h30303030, 0, c);
    wr(1, 32'h10101010, 0, c);
    wr(0, 32'h00000000, 0, c);
    wr(2, 32'h20202020, 0, c);
    chk("post_rst_vector", out_vector, 128'h30303030_20202020_10101010_00000000);

    // Reset while holding
    do_reset();

    // Randomized vectors
    for (int v = 0; v < 40; v++) begin
      c = 1'b0;
      while (!c) wr($urandom_range(0, 3), $urandom, ($urandom_range(0, 5) == 0), c);
      consume($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
